alu_pipe_mc: RTL and testbench

Parametrised, handshaked successor to the 16-bit ripple ALU for the CPU datapath. Adds registered outputs, valid/ready flow control, shifts, XOR, unsigned compare, status flags and an optional iterative unsigned multiplier. Single-cycle ops have 1-cycle latency at full throughput; MUL is multi-cycle. It sits between register-read and writeback in the execute stage.

---
 rtl/alu_pipe_mc.sv | 179 +++++++++++++++++
 tb/tb_alu_pipe_mc.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_mc.sv
// rtl/alu_pipe_mc.sv - handshaked pipelined ALU with optional iterative multiplier (ALU_MUL_EN)
`timescale 1ns/1ps
module alu_pipe_mc #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             illegal
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SLL  = 4'b0011;
   localparam logic [3:0] OP_SRL  = 4'b0100;
   localparam logic [3:0] OP_SRA  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_XOR  = 4'b1001;
   localparam logic [3:0] OP_NOR  = 4'b1100;

   logic [WIDTH:0]   add_full;
   logic [WIDTH:0]   sub_full;
   logic [SHW-1:0]   shamt;
   logic             add_ov;
   logic             sub_ov;
   logic [WIDTH-1:0] c_res;
   logic             c_carry;
   logic             c_ov;
   logic             c_ill;
   logic             accept;

   // subtraction is a + ~b + 1 so its carry-out means "no borrow"
   assign add_full = {1'b0, a} + {1'b0, b};
   assign sub_full = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
   assign shamt    = b[SHW-1:0];
   assign add_ov   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
   assign sub_ov   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
   assign accept   = in_valid && in_ready;

   // single-cycle datapath; anything not decoded here (including MUL when absent) is illegal
   always_comb begin
      c_res   = '0;
      c_carry = 1'b0;
      c_ov    = 1'b0;
      c_ill   = 1'b0;
      case (op)
         OP_AND:  c_res = a & b;
         OP_OR:   c_res = a | b;
         OP_XOR:  c_res = a ^ b;
         OP_NOR:  c_res = ~(a | b);
         OP_ADD:  begin c_res = add_full[WIDTH-1:0]; c_carry = add_full[WIDTH]; c_ov = add_ov; end
         OP_SUB:  begin c_res = sub_full[WIDTH-1:0]; c_carry = sub_full[WIDTH]; c_ov = sub_ov; end
         OP_SLT:  begin c_res = WIDTH'(sub_full[WIDTH-1] ^ sub_ov); c_carry = sub_full[WIDTH]; end
         OP_SLTU: begin c_res = WIDTH'(!sub_full[WIDTH]); c_carry = sub_full[WIDTH]; end
         OP_SLL:  c_res = a << shamt;
         OP_SRL:  c_res = a >> shamt;
         OP_SRA:  c_res = $unsigned($signed(a) >>> shamt);
         default: c_ill = 1'b1;
      endcase
   end

`ifdef ALU_MUL_EN
   localparam logic [3:0] OP_MUL = 4'b1010;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [SHW-1:0]   cnt;
   logic [WIDTH:0]   step_sum;
   logic [WIDTH-1:0] nxt_hi;
   logic [WIDTH-1:0] nxt_lo;

   // one shift-and-add step: acc_lo starts as the multiplier and is shifted out as product bits shift in
   assign step_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
   assign nxt_hi   = step_sum[WIDTH:1];
   assign nxt_lo   = {step_sum[0], acc_lo[WIDTH-1:1]};
   assign in_ready = (state == IDLE) && (!out_valid || out_ready);

   // control FSM plus output register; the last multiply step feeds the output register directly
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         result_hi <= '0;
         zero      <= 1'b0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         illegal   <= 1'b0;
         mcand     <= '0;
         acc_hi    <= '0;
         acc_lo    <= '0;
         cnt       <= '0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept && op == OP_MUL) begin
                  state  <= BUSY;
                  mcand  <= a;
                  acc_hi <= '0;
                  acc_lo <= b;
                  cnt    <= '0;
               end else if (accept) begin
                  out_valid <= 1'b1;
                  result    <= c_res;
                  result_hi <= '0;
                  zero      <= (c_res == '0);
                  carry     <= c_carry;
                  overflow  <= c_ov;
                  illegal   <= c_ill;
               end
            end
            BUSY: begin
               acc_hi <= nxt_hi;
               acc_lo <= nxt_lo;
               cnt    <= cnt + SHW'(1);
               if (cnt == SHW'(WIDTH-1)) begin
                  state     <= IDLE;
                  out_valid <= 1'b1;
                  result    <= nxt_lo;
                  result_hi <= nxt_hi;
                  zero      <= ({nxt_hi, nxt_lo} == '0);
                  carry     <= 1'b0;
                  overflow  <= 1'b0;
                  illegal   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   assign in_ready = !out_valid || out_ready;

   // output register; without the multiplier every op completes in one cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         result    <= '0;
         result_hi <= '0;
         zero      <= 1'b0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (accept) begin
            out_valid <= 1'b1;
            result    <= c_res;
            result_hi <= '0;
            zero      <= (c_res == '0);
            carry     <= c_carry;
            overflow  <= c_ov;
            illegal   <= c_ill;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_pipe_mc.sv
// tb/tb_alu_pipe_mc.sv - scoreboard bench for alu_pipe_mc
`timescale 1ns/1ps
module tb_alu_pipe_mc;

   typedef struct packed {
      logic [15:0] res;
      logic [15:0] hi;
      logic        z;
      logic        c;
      logic        v;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic [3:0]  op = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] result;
   logic [15:0] result_hi;
   logic        zero;
   logic        carry;
   logic        overflow;
   logic        illegal;

   exp_t q[$];
   int   pop_cyc[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;

   alu_pipe_mc #(.WIDTH(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .result_hi(result_hi), .zero(zero), .carry(carry),
      .overflow(overflow), .illegal(illegal)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t mk(input logic [15:0] r, input logic [15:0] h,
                               input logic z, input logic c, input logic v, input logic il);
      mk = '{res: r, hi: h, z: z, c: c, v: v, ill: il};
   endfunction

   // monitor: pops the scoreboard whenever a result is handed over
   always @(negedge clk) begin
      exp_t got;
      exp_t e;
      if (!reset && out_valid && out_ready) begin
         got = {result, result_hi, zero, carry, overflow, illegal};
         n_cmp++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_result got res=%h hi=%h flags zcvi=%b%b%b%b",
                     result, result_hi, zero, carry, overflow, illegal);
         end else begin
            e = q.pop_front();
            if (got !== e)begin
               n_bad++;
               $display("FAIL result got res=%h hi=%h zcvi=%b%b%b%b want res=%h hi=%h zcvi=%b%b%b%b",
                        got.res, got.hi, got.z, got.c, got.v, got.ill,
                        e.res, e.hi, e.z, e.c, e.v, e.ill);
            end
         end
         pop_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got %h want %h", nm, got, want);
      end
   endtask

   // present one op, wait (bounded) for acceptance; in_valid stays high so calls can stream
   task automatic send(input logic [3:0] o, input logic [15:0] aa, input logic [15:0] bb,
                       input exp_t e, input bit push);
      int t;
      t = 0;
      op = o; a = aa; b = bb; in_valid = 1'b1;
      while (!in_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 100) chk("accept_timeout", 64'(t), 64'(0));
      if (push) q.push_back(e);
      @(posedge clk); #1;
   endtask

   // cycles from accept to out_valid, also tracking that in_ready stayed low while waiting
   task automatic check_lat(input string nm, input int want, input bit check_busy);
      int lat;
      bit ir_low;
      lat = 1;
      ir_low = 1'b1;
      while (!out_valid && lat < 60) begin
         if (in_ready) ir_low = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      chk(nm, 64'(lat), 64'(want));
      if (check_busy) chk("busy_in_ready_low", 64'(ir_low), 64'(1));
   endtask

   initial begin
      logic [36:0] snap;
      int n0;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("reset_outputs", {out_valid, result, result_hi, zero, carry, overflow, illegal}, 64'(0));
      chk("reset_in_ready", 64'(in_ready), 64'(1));

      send(4'b0010, 16'h7FFF, 16'h0001, mk(16'h8000, 16'h0, 0, 0, 1, 0), 1);
      in_valid = 1'b0;
      check_lat("add_latency", 1, 0);

      send(4'b0110, 16'h0005, 16'h0005, mk(16'h0000, 16'h0, 1, 1, 0, 0), 1);
      send(4'b0111, 16'h8000, 16'h0001, mk(16'h0001, 16'h0, 0, 1, 0, 0), 1);
      send(4'b1000, 16'h8000, 16'h0001, mk(16'h0000, 16'h0, 1, 1, 0, 0), 1);
      send(4'b0101, 16'h8000, 16'h0013, mk(16'hF000, 16'h0, 0, 0, 0, 0), 1);
      send(4'b0011, 16'h0001, 16'h000F, mk(16'h8000, 16'h0, 0, 0, 0, 0), 1);
      send(4'b1111, 16'h1234, 16'h5678, mk(16'h0000, 16'h0, 1, 0, 0, 1), 1);
      send(4'b0010, 16'hFFFF, 16'h0001, mk(16'h0000, 16'h0, 1, 1, 0, 0), 1);
      send(4'b0100, 16'h8000, 16'h0004, mk(16'h0800, 16'h0, 0, 0, 0, 0), 1);
      send(4'b1001, 16'hF0F0, 16'hFF00, mk(16'h0FF0, 16'h0, 0, 0, 0, 0), 1);
      send(4'b1100, 16'h0F0F, 16'hF000, mk(16'h00F0, 16'h0, 0, 0, 0, 0), 1);
      send(4'b0000, 16'h1234, 16'h0F0F, mk(16'h0204, 16'h0, 0, 0, 0, 0), 1);
      send(4'b0001, 16'h1200, 16'h0034, mk(16'h1234, 16'h0, 0, 0, 0, 0), 1);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;

`ifdef ALU_MUL_EN
      send(4'b1010, 16'hFFFF, 16'hFFFF, mk(16'h0001, 16'hFFFE, 0, 0, 0, 0), 1);
      in_valid = 1'b0;
      check_lat("mul_latency", 17, 1);
`else
      send(4'b1010, 16'hFFFF, 16'hFFFF, mk(16'h0000, 16'h0000, 1, 0, 0, 1), 1);
      in_valid = 1'b0;
      check_lat("mul_illegal_latency", 1, 0);
`endif
      repeat (2) @(posedge clk);
      #1;

      out_ready = 1'b0;
      send(4'b0010, 16'h0001, 16'h0002, mk(16'h0003, 16'h0, 0, 0, 0, 0), 1);
      in_valid = 1'b0;
      snap = {out_valid, result, result_hi, zero, carry, overflow, illegal};
      chk("bp_valid", 64'(out_valid), 64'(1));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("bp_stable", {out_valid, result, result_hi, zero, carry, overflow, illegal}, 64'(snap));
         chk("bp_in_ready", 64'(in_ready), 64'(0));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;

      n0 = pop_cyc.size();
      for (int i = 1; i <= 4; i++)
         send(4'b0010, 16'(i * 16'h0100), 16'(i), mk(16'(i * 16'h0101), 16'h0, 0, 0, 0, 0), 1);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("stream_count", 64'(pop_cyc.size() - n0), 64'(4));
      if (pop_cyc.size() >= n0 + 4)
         chk("stream_consecutive", 64'(pop_cyc[n0+3] - pop_cyc[n0]), 64'(3));

`ifdef ALU_MUL_EN
      send(4'b1010, 16'h1234, 16'h5678, mk(16'h0, 16'h0, 0, 0, 0, 0), 0);
`else
      send(4'b1010, 16'h1234, 16'h5678, mk(16'h0000, 16'h0000, 1, 0, 0, 1), 1);
`endif
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_result", {result_hi, result}, 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      repeat (40) @(posedge clk);
      #1;
      chk("scoreboard_empty", 64'(q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
